// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter between N_REQ byte requesters.
// Optional packet lock (hold grant until req_last) enabled by defining UART_ARB_LOCK_EN.
module uart_tx_arb #(
    parameter int N_REQ      = 4,
    parameter int ID_W       = 2,
    parameter int GAP_CYCLES = 0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   req_data,
    input  logic [N_REQ-1:0]     req_last,
    output logic [N_REQ-1:0]     req_ack,
    output logic                 tx_vld,
    output logic [7:0]           tx_data,
    input  logic                 txrdy,
    output logic [ID_W-1:0]      gnt_id,
    output logic                 busy
);

    typedef enum logic [1:0] {IDLE, WAIT_LOW, WAIT_HIGH, GAP} state_t;

    state_t            state, state_nxt;
    logic [ID_W-1:0]   ptr, ptr_nxt;
    logic [15:0]       gap_cnt, gap_cnt_nxt;
    logic [N_REQ-1:0]  elig;
    logic              win_vld;
    logic [ID_W-1:0]   win_id;
    int unsigned       idx;
    logic              vld_nxt;
    logic [N_REQ-1:0]  ack_nxt;
    logic [7:0]        data_nxt;
    logic [ID_W-1:0]   gnt_nxt;

`ifdef UART_ARB_LOCK_EN
    logic lock, lock_nxt;
    assign elig = lock ? (req & (N_REQ'(1) << ptr)) : req;
`else
    logic unused_last;
    assign unused_last = ^req_last;
    assign elig        = req;
`endif

    // Later iterations overwrite earlier ones, so ptr+1 ends up with top priority.
    always_comb begin
        win_vld = 1'b0;
        win_id  = '0;
        idx     = 0;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            idx = (32'(ptr) + N_REQ - k) % N_REQ;
            if (elig[idx]) begin
                win_vld = 1'b1;
                win_id  = ID_W'(idx);
            end
        end
    end

    always_comb begin
        state_nxt   = state;
        ptr_nxt     = ptr;
        gap_cnt_nxt = gap_cnt;
        vld_nxt     = 1'b0;
        ack_nxt     = '0;
        data_nxt    = tx_data;
        gnt_nxt     = gnt_id;
`ifdef UART_ARB_LOCK_EN
        lock_nxt    = lock;
`endif
        case (state)
            IDLE: begin
                if (txrdy && win_vld) begin
                    vld_nxt   = 1'b1;
                    data_nxt  = req_data[8*int'(win_id) +: 8];
                    ack_nxt   = N_REQ'(1) << win_id;
                    gnt_nxt   = win_id;
                    ptr_nxt   = win_id;
                    state_nxt = WAIT_LOW;
`ifdef UART_ARB_LOCK_EN
                    lock_nxt  = !req_last[win_id];
`endif
                end
            end
            WAIT_LOW: begin
                if (!txrdy) state_nxt = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (txrdy) begin
                    if (GAP_CYCLES > 0) begin
                        gap_cnt_nxt = 16'(GAP_CYCLES - 1);
                        state_nxt   = GAP;
                    end else begin
                        state_nxt   = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt == '0) state_nxt = IDLE;
                else               gap_cnt_nxt = gap_cnt - 16'd1;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            ptr     <= ID_W'(N_REQ - 1);
            gap_cnt <= '0;
            tx_vld  <= 1'b0;
            tx_data <= '0;
            req_ack <= '0;
            gnt_id  <= '0;
            busy    <= 1'b0;
`ifdef UART_ARB_LOCK_EN
            lock    <= 1'b0;
`endif
        end else begin
            state   <= state_nxt;
            ptr     <= ptr_nxt;
            gap_cnt <= gap_cnt_nxt;
            tx_vld  <= vld_nxt;
            tx_data <= data_nxt;
            req_ack <= ack_nxt;
            gnt_id  <= gnt_nxt;
            busy    <= (state_nxt != IDLE);
`ifdef UART_ARB_LOCK_EN
            lock    <= lock_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: per-cycle behavioural model plus directed literal checks.
module tb_uart_tx_arb;
    localparam int N     = 4;
    localparam int GAP_M = 0;
    localparam int FRAME = 6;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b0;
    logic [3:0]  req, req_last, req_ack;
    logic [31:0] req_data;
    logic        tx_vld, txrdy, busy;
    logic [7:0]  tx_data;
    logic [1:0]  gnt_id;
    logic        tx_auto, man_rdy;
    logic        auto_rdy = 1'b1;
    int          fcnt = 0;
    assign txrdy = tx_auto ? auto_rdy : man_rdy;

    logic [3:0]  req_g, ack_g;
    logic [31:0] data_g;
    logic        vld_g, txrdy_g, busy_g;
    logic [7:0]  txd_g;
    logic [1:0]  gnt_g;

    int passed = 0;
    int total  = 0;
    logic [7:0] log_data[$];
    int         log_gnt[$];

    uart_tx_arb #(.N_REQ(4), .ID_W(2), .GAP_CYCLES(0)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_last(req_last),
        .req_ack(req_ack), .tx_vld(tx_vld), .tx_data(tx_data), .txrdy(txrdy),
        .gnt_id(gnt_id), .busy(busy));

    uart_tx_arb #(.N_REQ(4), .ID_W(2), .GAP_CYCLES(5)) dut_g (
        .clk(clk), .rst(rst), .req(req_g), .req_data(data_g), .req_last(4'b1111),
        .req_ack(ack_g), .tx_vld(vld_g), .tx_data(txd_g), .txrdy(txrdy_g),
        .gnt_id(gnt_g), .busy(busy_g));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Transmitter stand-in: goes busy the cycle after tx_vld, idle again after FRAME cycles.
    always @(negedge clk) begin
        if (!rst) begin
            auto_rdy = 1'b1;
            fcnt     = 0;
        end else if (tx_vld) begin
            auto_rdy = 1'b0;
            fcnt     = FRAME;
        end else if (fcnt > 0) begin
            fcnt--;
            if (fcnt == 0) auto_rdy = 1'b1;
        end
    end

    // Behavioural model: a rotating pointer, a busy flag and frame-phase bookkeeping.
    int unsigned m_ptr = N - 1;
    bit          m_busy, m_low, m_lock, found;
    int          m_gap, idx;
    logic        e_vld;
    logic [3:0]  e_ack;
    logic [1:0]  e_gnt;
    logic [7:0]  e_data;

    always @(posedge clk) begin
        if (!rst) begin
            m_ptr = N - 1; m_busy = 0; m_low = 0; m_gap = 0; m_lock = 0;
            e_vld = 0; e_ack = 0; e_gnt = 0; e_data = 0;
        end else begin
            e_vld = 0;
            e_ack = 0;
            if (!m_busy) begin
                if (txrdy) begin
                    found = 0;
                    for (int k = 1; k <= N; k++) begin
                        if (!found) begin
                            idx = (int'(m_ptr) + k) % N;
                            if (req[idx] && (!m_lock || idx == int'(m_ptr))) begin
                                found  = 1;
                                e_vld  = 1;
                                e_ack  = 4'(1 << idx);
                                e_gnt  = 2'(idx);
                                e_data = req_data[8*idx +: 8];
                                m_ptr  = idx;
                                m_busy = 1; m_low = 0; m_gap = 0;
`ifdef UART_ARB_LOCK_EN
                                m_lock = !req_last[idx];
`endif
                            end
                        end
                    end
                end
            end else if (!m_low) begin
                if (!txrdy) m_low = 1;
            end else if (m_gap > 0) begin
                m_gap--;
                if (m_gap == 0) m_busy = 0;
            end else if (txrdy) begin
                if (GAP_M == 0) m_busy = 0;
                else            m_gap = GAP_M;
            end
        end
        #1;
        check("m_tx_vld", tx_vld, e_vld);
        check("m_req_ack", req_ack, e_ack);
        check("m_gnt_id", gnt_id, e_gnt);
        check("m_busy", busy, m_busy);
        if (e_vld) check("m_tx_data", tx_data, e_data);
        if (tx_vld) begin
            log_data.push_back(tx_data);
            log_gnt.push_back(gnt_id);
        end
    end

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        @(negedge clk);
        while (busy !== 1'b0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check({name, "_idle"}, busy, 0);
    endtask

    task automatic wait_log(input int n, input string name);
        int c;
        c = 0;
        while (log_data.size() < n && c < 500) begin
            @(negedge clk);
            c++;
        end
        check({name, "_count"}, 32'(log_data.size() >= n), 1);
    endtask

    task automatic reset_pulse();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    logic [7:0] exp3[5] = '{8'hA0, 8'hA1, 8'hA2, 8'hA3, 8'hA0};
    int base;

    initial begin
        req = '0; req_data = '0; req_last = 4'b1111; tx_auto = 1'b1; man_rdy = 1'b1;
        req_g = '0; data_g = '0; txrdy_g = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b1;

        // Idle after reset
        repeat (100) @(negedge clk);
        check("idle_vld", tx_vld, 0);
        check("idle_busy", busy, 0);
        check("idle_data", tx_data, 8'h00);
        check("idle_ack", req_ack, 0);
        check("idle_gnt", gnt_id, 0);
        check("idle_log", log_data.size(), 0);

        // Single byte, one-cycle latency, no repeat pulse
        req_data[7:0] = 8'h55;
        req = 4'b0001;
        @(posedge clk); #1;
        check("single_vld", tx_vld, 1);
        check("single_data", tx_data, 8'h55);
        check("single_ack", req_ack, 4'b0001);
        @(negedge clk);
        req = '0;
        wait_idle("single");
        repeat (3) @(negedge clk);
        check("single_pulses", log_data.size(), 1);

        // All four requesting: strict rotation from requester 0
        reset_pulse();
        base = log_data.size();
        req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
        req = 4'b1111;
        wait_log(base + 5, "rr");
        req = '0;
        for (int i = 0; i < 5; i++) begin
            check("rr_data", log_data[base+i], exp3[i]);
            check("rr_gnt", log_gnt[base+i], i % 4);
        end
        wait_idle("rr");

        // txrdy held low blocks issue
        tx_auto = 1'b0;
        man_rdy = 1'b0;
        base = log_data.size();
        req_data[15:8] = 8'h42;
        req = 4'b0010;
        repeat (10) @(negedge clk);
        check("hold_log", log_data.size(), base);
        check("hold_busy", busy, 0);
        man_rdy = 1'b1;
        @(posedge clk); #1;
        check("hold_vld", tx_vld, 1);
        check("hold_gnt", gnt_id, 1);
        check("hold_data", tx_data, 8'h42);
        @(negedge clk);
        req = '0;
        tx_auto = 1'b1;
        wait_idle("hold");

`ifdef UART_ARB_LOCK_EN
        // Packet lock: requester 0 sends 3 bytes while requester 1 waits
        reset_pulse();
        base = log_data.size();
        req_data[7:0] = 8'h10;
        req_data[15:8] = 8'h20;
        req_last = 4'b1110;
        req = 4'b0011;
        for (int j = 0; j < 3; j++) begin
            wait_log(base + j + 1, "lock");
            if (j < 2) begin
                req_data[7:0] = 8'(8'h11 + j);
                req_last[0] = (j == 1);
            end else begin
                req[0] = 1'b0;
            end
        end
        wait_log(base + 4, "lock");
        req = '0;
        req_last = 4'b1111;
        check("lock_b0", log_data[base], 8'h10);
        check("lock_b1", log_data[base+1], 8'h11);
        check("lock_b2", log_data[base+2], 8'h12);
        check("lock_b3", log_data[base+3], 8'h20);
        wait_idle("lock");
`endif

        // Reset asserted mid-frame
        reset_pulse();
        base = log_data.size();
        req_data[23:16] = 8'h66;
        req_data[15:8] = 8'h77;
        req = 4'b0100;
        wait_log(base + 1, "mid");
        req = 4'b0010;
        repeat (3) @(negedge clk);
        check("mid_pre_busy", busy, 1);
        check("mid_pre_gnt", gnt_id, 2);
        rst = 1'b0;
        #1;
        check("mid_vld", tx_vld, 0);
        check("mid_busy", busy, 0);
        check("mid_gnt", gnt_id, 0);
        check("mid_ack", req_ack, 0);
        check("mid_data", tx_data, 8'h00);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk); #1;
        check("mid_post_vld", tx_vld, 1);
        check("mid_post_gnt", gnt_id, 1);
        check("mid_post_data", tx_data, 8'h77);
        @(negedge clk);
        req = '0;
        wait_idle("mid");

        // Idle gap of 5 cycles on the second instance
        data_g = {16'h0, 8'h3D, 8'h3C};
        req_g = 4'b0001;
        @(posedge clk); #1;
        check("gap_first_vld", vld_g, 1);
        check("gap_first_data", txd_g, 8'h3C);
        @(negedge clk);
        req_g = '0;
        @(negedge clk);
        txrdy_g = 1'b0;
        repeat (3) @(negedge clk);
        req_g = 4'b0010;
        txrdy_g = 1'b1;
        for (int i = 0; i < 7; i++) begin
            @(posedge clk); #1;
            if (i < 6) check("gap_novld", vld_g, 0);
            else begin
                check("gap_vld", vld_g, 1);
                check("gap_gnt", gnt_g, 1);
                check("gap_data", txd_g, 8'h3D);
            end
            if (i < 5) check("gap_busy", busy_g, 1);
            if (i == 5) check("gap_idle_busy", busy_g, 0);
        end
        @(negedge clk);
        req_g = '0;

        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d so far", passed, total);
        $fatal(1);
    end
endmodule
